// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, next-PC selection, instruction memory
// and the IF/ID pipeline latch, plus a small IDLE/RUN/HALT run-control FSM used by
// the debug unit to load the program, start execution and observe halt.
module fetch_stage #(
  parameter int unsigned         NB_PC       = 32,
  parameter int unsigned         NB_INST     = 32,
  parameter int unsigned         NB_MEM_ADDR = 10,
  parameter logic [NB_INST-1:0]  HALT_INST   = {NB_INST{1'b1}}
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_start,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic                   i_jump,
  input  logic [NB_PC-1:0]       i_jump_addr,
  input  logic                   i_branch,
  input  logic [NB_PC-1:0]       i_branch_addr,
  input  logic                   i_mem_wr_en,
  input  logic [NB_MEM_ADDR-1:0] i_mem_wr_addr,
  input  logic [NB_INST-1:0]     i_mem_wr_data,
  output logic [NB_INST-1:0]     o_if_id_inst,
  output logic [NB_PC-1:0]       o_if_id_pc_plus1,
  output logic [NB_PC-1:0]       o_pc,
  output logic                   o_running,
  output logic                   o_halted
);

  localparam int unsigned MemDepth = 1 << NB_MEM_ADDR;

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e             state_q, state_d;
  logic [NB_PC-1:0]   pc_q, pc_d;
  logic [NB_INST-1:0] inst_q, inst_d;
  logic [NB_PC-1:0]   pc1_q, pc1_d;
  logic               mem_we;

  logic [NB_INST-1:0] mem [MemDepth];
  logic [NB_INST-1:0] fetch_inst;
  logic [NB_PC-1:0]   pc_plus1;

  // Combinational read; index wraps on the low PC bits.
  assign fetch_inst = mem[pc_q[NB_MEM_ADDR-1:0]];
  assign pc_plus1   = pc_q + NB_PC'(1);

  // Program memory: loaded by the debug unit only while idle, never cleared by reset.
  always_ff @(posedge i_clock) begin
    if (mem_we) begin
      mem[i_mem_wr_addr] <= i_mem_wr_data;
    end
  end

  // Next-state for FSM, PC and IF/ID latch; nothing moves while i_enable is low.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc1_d   = pc1_q;
    mem_we  = 1'b0;
    if (i_enable) begin
      case (state_q)
        StIdle: begin
          mem_we = i_mem_wr_en;
          if (i_start) begin
            state_d = StRun;
          end
        end
        StRun: begin
          // Redirects win over stall for the PC.
          if (i_branch) begin
            pc_d = i_branch_addr;
          end else if (i_jump) begin
            pc_d = i_jump_addr;
          end else if (!i_stall) begin
            pc_d = pc_plus1;
          end
          if (i_flush) begin
            inst_d = '0;
            pc1_d  = '0;
          end else if (!i_stall) begin
            inst_d = fetch_inst;
            pc1_d  = pc_plus1;
            // Halt only once the halt word actually enters the pipeline.
            if (fetch_inst == HALT_INST) begin
              state_d = StHalt;
            end
          end
        end
        StHalt: begin
          // Drain: feed NOPs so the halt word passes downstream exactly once.
          inst_d = '0;
          pc1_d  = '0;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      inst_q  <= '0;
      pc1_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc1_q   <= pc1_d;
    end
  end

  assign o_if_id_inst     = inst_q;
  assign o_if_id_pc_plus1 = pc1_q;
  assign o_pc             = pc_q;
  assign o_running        = (state_q == StRun);
  assign o_halted         = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// compared against a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, start, stall, flush, jump, branch, wr_en;
  logic [31:0] jaddr, baddr, wr_data;
  logic [9:0]  wr_addr;
  logic [31:0] if_inst, if_pc1, pc;
  logic        running, halted;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model
  logic [31:0] m_mem [1024];
  logic [31:0] m_pc, m_inst, m_pc1;
  bit          m_run, m_halt;

  always #5 clk = ~clk;

  fetch_stage dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_enable        (en),
    .i_start         (start),
    .i_stall         (stall),
    .i_flush         (flush),
    .i_jump          (jump),
    .i_jump_addr     (jaddr),
    .i_branch        (branch),
    .i_branch_addr   (baddr),
    .i_mem_wr_en     (wr_en),
    .i_mem_wr_addr   (wr_addr),
    .i_mem_wr_data   (wr_data),
    .o_if_id_inst    (if_inst),
    .o_if_id_pc_plus1(if_pc1),
    .o_pc            (pc),
    .o_running       (running),
    .o_halted        (halted)
  );

  task automatic model_reset();
    m_pc = 0; m_inst = 0; m_pc1 = 0; m_run = 0; m_halt = 0;
  endtask

  // Apply one enabled clock edge to the model from the current inputs.
  task automatic model_edge();
    logic [31:0] f, old_pc;
    if (!en) return;
    if (m_halt) begin
      m_inst = 0; m_pc1 = 0;
    end else if (!m_run) begin
      if (wr_en) m_mem[wr_addr] = wr_data;
      if (start) m_run = 1;
    end else begin
      old_pc = m_pc;
      f = m_mem[old_pc % 1024];
      if (branch) m_pc = baddr;
      else if (jump) m_pc = jaddr;
      else if (!stall) m_pc = old_pc + 1;
      if (flush) begin
        m_inst = 0; m_pc1 = 0;
      end else if (!stall) begin
        m_inst = f; m_pc1 = old_pc + 1;
        if (f == HALT) begin m_run = 0; m_halt = 1; end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    en = 1; start = 0; stall = 0; flush = 0; jump = 0; branch = 0; wr_en = 0;
    jaddr = 0; baddr = 0; wr_addr = 0; wr_data = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1; model_reset();
    #2;
    rst = 0;
  endtask

  task automatic load_word(input logic [9:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic start_run();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1; model_reset();
    #1;
    n_checks++; if (pc !== 0) begin n_errors++; $display("FAIL reset_pc: got %0h want 0", pc); end
    n_checks++; if (if_inst !== 0) begin n_errors++; $display("FAIL reset_inst: got %0h want 0", if_inst); end
    n_checks++; if (if_pc1 !== 0) begin n_errors++; $display("FAIL reset_pc1: got %0h want 0", if_pc1); end
    n_checks++; if (running !== 0 || halted !== 0) begin
      n_errors++; $display("FAIL reset_state: got run=%0b halt=%0b want 0 0", running, halted);
    end
    rst = 0;
    #1;
    for (int i = 0; i < 16; i++) load_word(10'(i), 32'hA000_0000 + i);
  endtask

  task automatic test_program_halt();
    do_reset();
    load_word(3, HALT);
    start_run();
    n_checks++; if (running !== 1 || pc !== 0) begin
      n_errors++; $display("FAIL start: got run=%0b pc=%0d want 1 0", running, pc);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (if_inst !== 32'hA000_0000 + i || if_pc1 !== i + 1) begin
        n_errors++; $display("FAIL seq_fetch%0d: got %0h/%0d want %0h/%0d", i, if_inst, if_pc1,
                             32'hA000_0000 + i, i + 1);
      end
    end
    tick();
    n_checks++; if (if_inst !== HALT || if_pc1 !== 4) begin
      n_errors++; $display("FAIL halt_latch: got %0h/%0d want %0h/4", if_inst, if_pc1, HALT);
    end
    n_checks++; if (halted !== 1 || running !== 0 || pc !== 4) begin
      n_errors++; $display("FAIL halt_state: got h=%0b r=%0b pc=%0d want 1 0 4", halted, running, pc);
    end
    tick();
    n_checks++; if (if_inst !== 0 || if_pc1 !== 0 || pc !== 4 || halted !== 1) begin
      n_errors++; $display("FAIL halt_drain: got %0h/%0d pc=%0d h=%0b want 0/0 4 1",
                           if_inst, if_pc1, pc, halted);
    end
    do_reset();
    load_word(3, 32'hA000_0003);
  endtask

  task automatic test_jump_flush();
    do_reset();
    start_run();
    tick(); tick();
    jump = 1; jaddr = 8; flush = 1;
    tick();
    jump = 0; flush = 0;
    n_checks++; if (pc !== 8 || if_inst !== 0 || if_pc1 !== 0) begin
      n_errors++; $display("FAIL jump_flush: got pc=%0d %0h/%0d want 8 0/0", pc, if_inst, if_pc1);
    end
    tick();
    n_checks++; if (if_inst !== 32'hA000_0008 || if_pc1 !== 9 || pc !== 9) begin
      n_errors++; $display("FAIL jump_target: got %0h/%0d pc=%0d want a0000008/9 9",
                           if_inst, if_pc1, pc);
    end
  endtask

  task automatic test_branch_priority();
    do_reset();
    start_run();
    branch = 1; baddr = 20; jump = 1; jaddr = 8;
    tick();
    branch = 0;
    n_checks++; if (pc !== 20 || if_inst !== 32'hA000_0000 || if_pc1 !== 1) begin
      n_errors++; $display("FAIL branch_prio: got pc=%0d %0h/%0d want 20 a0000000/1",
                           pc, if_inst, if_pc1);
    end
    stall = 1;
    tick();
    jump = 0; stall = 0;
    n_checks++; if (pc !== 8 || if_inst !== 32'hA000_0000 || if_pc1 !== 1) begin
      n_errors++; $display("FAIL redirect_over_stall: got pc=%0d %0h/%0d want 8 a0000000/1",
                           pc, if_inst, if_pc1);
    end
  endtask

  task automatic test_stall();
    do_reset();
    start_run();
    for (int i = 0; i < 5; i++) tick();
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (pc !== 5 || if_inst !== 32'hA000_0004 || if_pc1 !== 5) begin
        n_errors++; $display("FAIL stall_hold%0d: got pc=%0d %0h/%0d want 5 a0000004/5",
                             i, pc, if_inst, if_pc1);
      end
    end
    stall = 0;
    tick();
    n_checks++; if (pc !== 6 || if_inst !== 32'hA000_0005 || if_pc1 !== 6) begin
      n_errors++; $display("FAIL stall_release: got pc=%0d %0h/%0d want 6 a0000005/6",
                           pc, if_inst, if_pc1);
    end
  endtask

  task automatic test_flush_stall_halt();
    do_reset();
    load_word(6, HALT);
    load_word(8, HALT);
    start_run();
    for (int i = 0; i < 6; i++) tick();
    flush = 1;
    tick();
    flush = 0;
    n_checks++; if (running !== 1 || halted !== 0 || pc !== 7 || if_inst !== 0) begin
      n_errors++; $display("FAIL flushed_halt: got r=%0b h=%0b pc=%0d inst=%0h want 1 0 7 0",
                           running, halted, pc, if_inst);
    end
    tick();
    stall = 1;
    tick();
    stall = 0;
    n_checks++; if (running !== 1 || pc !== 8 || if_inst !== 32'hA000_0007) begin
      n_errors++; $display("FAIL stalled_halt: got r=%0b pc=%0d inst=%0h want 1 8 a0000007",
                           running, pc, if_inst);
    end
    tick();
    n_checks++; if (halted !== 1 || if_inst !== HALT || if_pc1 !== 9 || pc !== 9) begin
      n_errors++; $display("FAIL late_halt: got h=%0b %0h/%0d pc=%0d want 1 ffffffff/9 9",
                           halted, if_inst, if_pc1, pc);
    end
    do_reset();
    load_word(6, 32'hA000_0006);
    load_word(8, 32'hA000_0008);
  endtask

  task automatic test_enable_freeze_reset();
    do_reset();
    en = 0; start = 1; wr_en = 1; wr_addr = 0; wr_data = HALT;
    tick();
    wr_en = 0;
    n_checks++; if (running !== 0) begin
      n_errors++; $display("FAIL disabled_start: got run=%0b want 0", running);
    end
    en = 1;
    tick();
    start = 0;
    tick();
    n_checks++; if (if_inst !== 32'hA000_0000 || running !== 1) begin
      n_errors++; $display("FAIL disabled_write: got %0h r=%0b want a0000000 1", if_inst, running);
    end
    tick(); tick();
    en = 0; stall = 1; flush = 1; jump = 1; jaddr = 77;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (pc !== 3 || if_inst !== 32'hA000_0002 || if_pc1 !== 3 || running !== 1) begin
        n_errors++; $display("FAIL freeze%0d: got pc=%0d %0h/%0d r=%0b want 3 a0000002/3 1",
                             i, pc, if_inst, if_pc1, running);
      end
    end
    clear_inputs();
    #2;
    rst = 1; model_reset();
    #1;
    n_checks++; if (pc !== 0 || if_inst !== 0 || if_pc1 !== 0 || running !== 0) begin
      n_errors++; $display("FAIL async_reset: got pc=%0d %0h/%0d r=%0b want 0 0/0 0",
                           pc, if_inst, if_pc1, running);
    end
    rst = 0;
  endtask

  function automatic logic [31:0] rand_word();
    return ($urandom_range(23) == 0) ? HALT : $urandom;
  endfunction

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1024; i++) load_word(10'(i), rand_word());
    for (int c = 0; c < 3000; c++) begin
      en     = ($urandom_range(7) != 0);
      start  = ($urandom_range(1) != 0);
      stall  = ($urandom_range(3) == 0);
      flush  = ($urandom_range(5) == 0);
      jump   = ($urandom_range(7) == 0);
      branch = ($urandom_range(9) == 0);
      jaddr  = $urandom;
      baddr  = $urandom;
      wr_en  = ($urandom_range(3) == 0);
      wr_addr = 10'($urandom);
      wr_data = rand_word();
      tick();
      n_checks++;
      if (pc !== m_pc || if_inst !== m_inst || if_pc1 !== m_pc1 ||
          running !== m_run || halted !== m_halt) begin
        n_errors++;
        $display("FAIL random c=%0d: got pc=%0h %0h/%0h r=%0b h=%0b want pc=%0h %0h/%0h r=%0b h=%0b",
                 c, pc, if_inst, if_pc1, running, halted, m_pc, m_inst, m_pc1, m_run, m_halt);
      end
      if ((m_halt && $urandom_range(3) == 0) || $urandom_range(149) == 0) begin
        #2;
        rst = 1; model_reset();
        #1;
        n_checks++;
        if (pc !== 0 || if_inst !== 0 || if_pc1 !== 0 || running !== 0 || halted !== 0) begin
          n_errors++; $display("FAIL random_reset c=%0d: got pc=%0h %0h/%0h r=%0b h=%0b want zeros",
                               c, pc, if_inst, if_pc1, running, halted);
        end
        rst = 0;
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_program_halt();
    test_jump_flush();
    test_branch_priority();
    test_stall();
    test_flush_stall_halt();
    test_enable_freeze_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
